muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit that feeds the datapath's HI/LO read path (mfhi/mflo select).
- Replaces the combinational multiply/divide with a one-bit-per-cycle engine.
- Accepts two register operands on a start pulse and runs WIDTH iterations.
- Holds the 2*WIDTH-bit product, or the quotient/remainder, in HI/LO until the next operation completes.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  operation request; sampled only in IDLE.
- op_div  in  1  0 = multiply, 1 = divide; captured with start.
- op_signed  in  1  1 = two's-complement operands, 0 = unsigned; captured with start.
- srca  in  WIDTH  multiplicand / dividend.
- srcb  in  WIDTH  multiplier / divisor.
- busy  out  1  high from the edge that accepts start until the edge that writes HI/LO.
- done  out  1  one-cycle pulse in the cycle after HI/LO are written.
- div_by_zero  out  1  sticky flag of the last completed operation; set if it was a divide with srcb == 0.
- hi  out  WIDTH  product[2W-1:W] or remainder.
- lo  out  WIDTH  product[W-1:0] or quotient.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; busy, done and div_by_zero = 0; hi and lo = 0; iteration counter = 0.
- Reset while RUN or FIX:
  - Aborts the operation immediately. No partial result reaches hi/lo.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE:
  - On an edge with start = 1: latch op_div and op_signed.
  - Latch the magnitudes of srca and srcb (two's-complement negate if op_signed and MSB = 1) and the result signs.
  - Clear the accumulator; counter = 0; go to RUN; busy = 1.
  - start with busy = 1 is ignored; there is no queueing.
- RUN: one iteration per edge; counter increments; after WIDTH iterations go to FIX.
  - Multiply (shift-add): if multiplier LSB = 1, add the multiplicand to the upper accumulator half, then shift the 2W+1-bit accumulator right by 1.
  - Divide (restoring): shift {rem, quo} left by 1, trial-subtract the divisor from rem. If non-negative, keep the difference and set quo LSB = 1.
- FIX (one edge):
  - Apply sign correction and write hi/lo.
  - busy falls; done = 1 for exactly the following cycle; return to IDLE.
- Latency:
  - start accepted at edge k.
  - hi/lo updated at edge k + WIDTH + 1.
  - done high during cycle k + WIDTH + 1 .. k + WIDTH + 2.
  - Back-to-back operation: start may be asserted in the done cycle and is accepted at that edge.
- Sign rules:
  - Product is negated if the operand signs differ (signed only).
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero:
  - Runs full latency.
  - Forces lo = all ones, hi = srca as captured (original, not magnitude).
  - div_by_zero = 1; it is cleared at the FIX of the next non-faulting operation.
- Signed overflow (-2^(W-1) / -1):
  - lo = 0x80000000, hi = 0 (natural W-bit truncation). No flag.
- hi/lo are stable at all times except the single FIX edge.
- srca and srcb may change freely after the start edge.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FIX = 2'd2;
  - op encoding OP_MUL = 1'b0, OP_DIV = 1'b1.
- One natural sub-module: muldiv_negate, a conditional two's-complement negator.
  - Used at operand capture and at FIX.
- Counter width is clog2(WIDTH) + 1.

Test Plan:
- Unsigned multiply: srca = 0xFFFFFFFF, srcb = 0xFFFFFFFF.
  - Required: done 33 cycles after start; hi = 0xFFFFFFFE, lo = 0x00000001.
- Signed multiply: srca = -7 (0xFFFFFFF9), srcb = 6.
  - Required: hi = 0xFFFFFFFF, lo = 0xFFFFFFD6 (-42).
- Signed divide: srca = -17, srcb = 5.
  - Required: lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFE (-2); unsigned 17/5 gives lo = 3, hi = 2.
- Divide by zero: srca = 0x1234, srcb = 0.
  - Required: lo = 0xFFFFFFFF, hi = 0x1234, div_by_zero = 1.
  - A following 10/2 clears the flag: lo = 5, hi = 0.
- Start during busy:
  - Second start 10 cycles into a multiply is ignored; first result unchanged.
  - Start in the done cycle is accepted and done pulses again 33 cycles later.
- Reset mid-RUN:
  - reset low at iteration 15: busy = 0 asynchronously, hi = lo = 0, no done pulse.
  - Next start completes normally.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negator: y = en ? -a : a.
module muldiv_negate
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  // Negate by invert-and-increment when enabled, otherwise pass through.
  always_comb begin
    y = a;
    if (en) y = (~a) + WIDTH'(1);
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative one-bit-per-cycle multiply/divide unit feeding the HI/LO read path.
// Operands are reduced to magnitudes at capture, an unsigned shift-add or
// restoring-divide engine runs WIDTH iterations, and signs are restored when
// HI/LO are written.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t            state;
  logic [CW-1:0]     cnt;

  // Operation context captured with start.
  logic              op_kind;
  logic              sign_a;
  logic              sign_b;
  logic [WIDTH-1:0]  srca_raw;
  // Multiplicand for multiply, divisor for divide (magnitude).
  logic [WIDTH-1:0]  opnd;
  // Multiply: {carry, product_hi, product_lo/multiplier}.
  // Divide:   {rem (WIDTH+1 bits), quo/dividend}.
  logic [2*WIDTH:0]  acc;

  logic              in_sign_a;
  logic              in_sign_b;
  logic [WIDTH-1:0]  mag_a;
  logic [WIDTH-1:0]  mag_b;
  logic              accept;

  logic [2*WIDTH:0]  acc_next;
  logic [WIDTH-1:0]  addend;
  logic [WIDTH:0]    upper;
  logic [WIDTH:0]    rem_sh;
  logic [WIDTH:0]    divisor_ext;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               res_neg;
  logic               dbz_now;

  assign in_sign_a = op_signed & srca[WIDTH-1];
  assign in_sign_b = op_signed & srcb[WIDTH-1];
  assign accept    = (state == ST_IDLE) && start;
  assign res_neg   = sign_a ^ sign_b;
  assign dbz_now   = (op_kind == OP_DIV) && (opnd == '0);

  muldiv_negate #(.WIDTH(WIDTH)) u_neg_a (.en(in_sign_a), .a(srca), .y(mag_a));
  muldiv_negate #(.WIDTH(WIDTH)) u_neg_b (.en(in_sign_b), .a(srcb), .y(mag_b));

  muldiv_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
    .en(res_neg), .a(acc[2*WIDTH-1:0]), .y(prod_fix)
  );
  muldiv_negate #(.WIDTH(WIDTH)) u_neg_quo (
    .en(res_neg), .a(acc[WIDTH-1:0]), .y(quo_fix)
  );
  muldiv_negate #(.WIDTH(WIDTH)) u_neg_rem (
    .en(sign_a), .a(acc[2*WIDTH-1:WIDTH]), .y(rem_fix)
  );

  // One engine iteration: shift-add for multiply, restoring step for divide.
  always_comb begin
    addend      = acc[0] ? opnd : '0;
    upper       = acc[2*WIDTH:WIDTH] + {1'b0, addend};
    rem_sh      = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    divisor_ext = {1'b0, opnd};
    acc_next    = {1'b0, upper, acc[WIDTH-1:1]};
    if (op_kind == OP_DIV) begin
      if (rem_sh >= divisor_ext)
        acc_next = {rem_sh - divisor_ext, acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {rem_sh, acc[WIDTH-2:0], 1'b0};
    end
  end

  // Datapath registers: operand capture on accept, one iteration per RUN edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_kind  <= op_div ? OP_DIV : OP_MUL;
      sign_a   <= in_sign_a;
      sign_b   <= in_sign_b;
      srca_raw <= srca;
      if (op_div) begin
        opnd <= mag_b;
        acc  <= {{(WIDTH+1){1'b0}}, mag_a};
      end else begin
        opnd <= mag_a;
        acc  <= {{(WIDTH+1){1'b0}}, mag_b};
      end
    end else if (state == ST_RUN) begin
      acc <= acc_next;
    end
  end

  // Control FSM and architectural HI/LO/flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= ST_FIX;
        end
        ST_FIX: begin
          div_by_zero <= dbz_now;
          if (op_kind == OP_DIV) begin
            if (dbz_now) begin
              hi <= srca_raw;
              lo <= '1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end else begin
            {hi, lo} <= prod_fix;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          op_div = 1'b0;
  logic          op_signed = 1'b0;
  logic [W-1:0]  srca = '0;
  logic [W-1:0]  srcb = '0;
  logic          busy;
  logic          done;
  logic          div_by_zero;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int n_chk  = 0;
  int n_pass = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op_div(op_div),
    .op_signed(op_signed), .srca(srca), .srcb(srcb), .busy(busy),
    .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference result from the arithmetic definition of each operation.
  function automatic void model(input bit d, input bit s, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] mh,
                                output logic [W-1:0] ml, output bit mz);
    longint          sp, sq, sr;
    longint unsigned up;
    mz = 0;
    if (!d) begin
      if (s) begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {mh, ml} = sp[63:0];
      end else begin
        up = longint'(a) * longint'(b);
        {mh, ml} = up[63:0];
      end
    end else if (b == 0) begin
      mh = a; ml = '1; mz = 1;
    end else if (s) begin
      sq = longint'($signed(a)) / longint'($signed(b));
      sr = longint'($signed(a)) % longint'($signed(b));
      ml = sq[W-1:0]; mh = sr[W-1:0];
    end else begin
      ml = a / b; mh = a % b;
    end
  endfunction

  // Issue one operation at the next negedge and follow it to done.
  // inject > 0 pulses a stray start that many cycles into the run.
  task automatic run_op(input string tag, input bit d, input bit s,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inject);
    logic [W-1:0] eh, el;
    bit ez;
    int n;
    bit seen;
    model(d, s, a, b, eh, el, ez);
    @(negedge clk);
    start = 1; op_div = d; op_signed = s; srca = a; srcb = b;
    @(posedge clk); #1;
    start = 0; op_div = $urandom; op_signed = $urandom;
    srca = $urandom; srcb = $urandom;
    check({tag, "_busy"}, 64'(busy), 64'(1));
    n = 0; seen = 0;
    while (n < 100 && !seen) begin
      @(posedge clk); #1;
      start = 0;
      n++;
      if (done) seen = 1;
      else if (n == inject) begin
        start = 1; op_div = ~d; srca = $urandom; srcb = $urandom;
      end
    end
    check({tag, "_lat"}, 64'(n), 64'(33));
    check({tag, "_busy_off"}, 64'(busy), 64'(0));
    check({tag, "_hi"}, 64'(hi), 64'(eh));
    check({tag, "_lo"}, 64'(lo), 64'(el));
    check({tag, "_dbz"}, 64'(div_by_zero), 64'(ez));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    bit rd, rs;
    int ndone;

    // Reset state
    #12;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dbz", 64'(div_by_zero), 64'(0));
    check("rst_hilo", {hi, lo}, 64'(0));
    @(negedge clk); reset = 1;

    run_op("umul_max", 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("umul_max_hi_abs", 64'(hi), 64'hFFFF_FFFE);
    check("umul_max_lo_abs", 64'(lo), 64'h1);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'(0));

    run_op("smul", 0, 1, 32'hFFFF_FFF9, 32'd6, 0);
    check("smul_lo_abs", 64'(lo), 64'hFFFF_FFD6);
    run_op("sdiv", 1, 1, -32'sd17, 32'd5, 0);
    check("sdiv_lo_abs", 64'(lo), 64'hFFFF_FFFD);
    check("sdiv_hi_abs", 64'(hi), 64'hFFFF_FFFE);
    run_op("udiv", 1, 0, 32'd17, 32'd5, 0);
    run_op("dbz", 1, 0, 32'h1234, 32'd0, 0);
    check("dbz_hi_abs", 64'(hi), 64'h1234);
    // Back-to-back: issued inside the done cycle of the divide by zero.
    check("b2b_done_cycle", 64'(done), 64'(1));
    run_op("dbz_clear", 1, 0, 32'd10, 32'd2, 0);
    run_op("sdbz", 1, 1, 32'hFFFF_FF00, 32'd0, 0);
    run_op("ovf", 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("ovf_lo_abs", 64'(lo), 64'h8000_0000);
    run_op("ignore_start", 0, 0, 32'd123456, 32'd789, 10);
    @(posedge clk); #1;
    check("ignore_no_rerun", 64'(busy), 64'(0));

    // Reset mid-RUN
    @(negedge clk);
    start = 1; op_div = 0; op_signed = 0; srca = 32'd99; srcb = 32'd77;
    @(posedge clk); #1; start = 0;
    repeat (15) @(posedge clk);
    @(negedge clk); reset = 0; #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_hilo", {hi, lo}, 64'(0));
    check("midrst_dbz", 64'(div_by_zero), 64'(0));
    @(negedge clk); reset = 1;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("midrst_no_done", 64'(ndone), 64'(0));
    run_op("after_rst", 0, 1, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 0);

    // Randomized operations with corner-biased operands.
    for (int i = 0; i < 40; i++) begin
      rd = $urandom; rs = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), rd, rs, ra, rb, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
